// File: rtl/hwpe_stream_addressgen_nd_pkg.sv
// Shared types for the N-dimensional streaming address generator.
// Control/flag bundles are sized for the maximum loop depth.
package hwpe_stream_package;

  localparam int unsigned HWPE_STREAM_ADDRESSGEN_ND_MAX_DIMS = 4;
  localparam int unsigned HWPE_STREAM_ADDRESSGEN_ND_MAX_CNT  = 32;
  localparam int unsigned HWPE_STREAM_ADDRESSGEN_ND_MAX_TOT  = 32;

  typedef struct packed {
    logic [31:0] base_addr;
    logic [HWPE_STREAM_ADDRESSGEN_ND_MAX_DIMS-1:0]
          [HWPE_STREAM_ADDRESSGEN_ND_MAX_CNT-1:0] length;
    logic [HWPE_STREAM_ADDRESSGEN_ND_MAX_DIMS-1:0]
          [31:0] stride;
  } ctrl_addressgen_nd_t;

  typedef struct packed {
    logic busy;
    logic done;
    logic first_of_line;
    logic last_of_line;
    logic [HWPE_STREAM_ADDRESSGEN_ND_MAX_DIMS-1:0] dim_wrap;
    logic [HWPE_STREAM_ADDRESSGEN_ND_MAX_TOT-1:0]  beat_cnt;
  } flags_addressgen_nd_t;

  typedef enum logic [1:0] {
    AG_IDLE,
    AG_RUN,
    AG_DONE
  } addressgen_nd_state_e;

endpackage

// File: rtl/hwpe_stream_addressgen_nd_cnt.sv
// One loop dimension: position counter plus stride accumulator.
// Accumulator tracks cnt*stride incrementally, so no multiplier.
module hwpe_stream_addressgen_nd_cnt #(
  parameter int unsigned W = 17
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         clear_i,
  input  logic         advance_i,
  input  logic [W-1:0] length_i,
  input  logic [31:0]  stride_i,
  output logic [31:0]  acc_o,
  output logic         first_o,
  output logic         last_o,
  output logic         wrap_o
);

  logic [W-1:0] r_cnt;
  logic [31:0]  r_acc;

  assign first_o = (r_cnt == '0);
  assign last_o  = (r_cnt == length_i - W'(1));
  assign wrap_o  = advance_i & last_o;
  assign acc_o   = r_acc;

  // step or wrap the position and its stride offset
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_cnt <= '0;
      r_acc <= '0;
    end else if (clear_i) begin
      r_cnt <= '0;
      r_acc <= '0;
    end else if (advance_i) begin
      if (last_o) begin
        r_cnt <= '0;
        r_acc <= '0;
      end else begin
        r_cnt <= r_cnt + W'(1);
        r_acc <= r_acc + stride_i;
      end
    end
  end

endmodule

// File: rtl/hwpe_stream_addressgen_nd.sv
// N-dimensional address generator with per-line misalignment.
// Emits one word address + byte strobe per valid/ready beat.
module hwpe_stream_addressgen_nd
  import hwpe_stream_package::*;
#(
  parameter int unsigned NB_DIMS = 3,
  parameter int unsigned STEP    = 4,
  parameter int unsigned CNT     = 16,
  parameter int unsigned TOT_CNT = 32
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 test_mode_i,
  input  logic                 enable_i,
  input  logic                 clear_i,
  input  logic                 start_i,
  input  ctrl_addressgen_nd_t  ctrl_i,
  output logic                 addr_valid_o,
  input  logic                 addr_ready_i,
  output logic [31:0]          addr_o,
  output logic [STEP-1:0]      strb_o,
  output flags_addressgen_nd_t flags_o
);

  localparam int unsigned OFFW = $clog2(STEP);
  localparam int unsigned CW   = CNT + 1;

  addressgen_nd_state_e r_state;

  logic [31:0]                 r_base;
  logic [NB_DIMS-1:0][CNT-1:0] r_len;
  logic [NB_DIMS-1:0][31:0]    r_stride;

  logic               r_valid;
  logic [31:0]        r_addr;
  logic [STEP-1:0]    r_strb;
  logic               r_first;
  logic               r_last_line;
  logic [NB_DIMS-1:0] r_dim_wrap;
  logic               r_last_beat;
  logic               r_busy;
  logic               r_done;
  logic [TOT_CNT-1:0] r_beat_cnt;

  logic                     w_idle;
  logic                     w_accept;
  logic                     w_hs;
  logic                     w_launch;
  logic [31:0]              w_base;
  logic [NB_DIMS-1:0][CW-1:0] w_len_eff;
  logic [NB_DIMS-1:0][31:0] w_acc;
  logic [NB_DIMS:0]         w_adv;
  logic [NB_DIMS-1:0]       w_wrap;
  logic [NB_DIMS-1:0]       w_first;
  logic [NB_DIMS-1:0]       w_last;
  logic [31:0]              w_line;
  logic [OFFW-1:0]          w_off;
  logic                     w_mis;
  logic [CW-1:0]            w_len0;
  logic [31:0]              w_addr;
  logic [STEP-1:0]          w_ones;
  logic [STEP-1:0]          w_head;
  logic [STEP-1:0]          w_strb;
  logic                     w_unused;

  assign w_idle   = (r_state == AG_IDLE);
  assign w_accept = w_idle & start_i & enable_i & ~clear_i;
  assign w_hs     = r_valid & addr_ready_i;
  assign w_launch = w_accept
                  | ((r_state == AG_RUN) & enable_i & ~clear_i
                     & ~r_last_beat & (~r_valid | addr_ready_i));
  assign w_adv[0] = w_launch;

  // in IDLE the first beat is built straight from ctrl_i
  always_comb begin
    w_base    = w_idle ? ctrl_i.base_addr : r_base;
    w_len_eff = '0;
    for (int d = 0; d < NB_DIMS; d++) begin
      w_len_eff[d] = {1'b0, (w_idle ? ctrl_i.length[d][CNT-1:0]
                                    : r_len[d])};
      if (w_len_eff[d] == '0) w_len_eff[d] = CW'(1);
    end
  end

  // line start, offset and beat address/strobe
  always_comb begin
    w_line = w_base;
    for (int d = 1; d < NB_DIMS; d++) begin
      w_line = w_line + w_acc[d];
    end
    w_off  = w_line[OFFW-1:0];
    w_mis  = |w_off;
    w_len0 = w_len_eff[0] + CW'(w_mis);
    w_addr = {w_line[31:OFFW], {OFFW{1'b0}}} + w_acc[0];
    w_ones = '1;
    w_head = w_ones << w_off;
    w_strb = w_ones;
    if (w_first[0]) w_strb = w_strb & w_head;
    if (w_last[0] && w_mis) w_strb = w_strb & ~w_head;
  end

  for (genvar d = 0; d < NB_DIMS; d++) begin : g_dim
    logic [CW-1:0] w_dlen;
    logic [31:0]   w_dstride;

    if (d == 0) begin : g_inner
      assign w_dlen    = w_len0;
      assign w_dstride = 32'(STEP);
    end else begin : g_outer
      assign w_dlen    = w_len_eff[d];
      assign w_dstride = w_idle ? ctrl_i.stride[d] : r_stride[d];
    end

    hwpe_stream_addressgen_nd_cnt #(
      .W (CW)
    ) i_cnt (
      .clk_i     (clk_i),
      .rst_ni    (rst_ni),
      .clear_i   (clear_i),
      .advance_i (w_adv[d]),
      .length_i  (w_dlen),
      .stride_i  (w_dstride),
      .acc_o     (w_acc[d]),
      .first_o   (w_first[d]),
      .last_o    (w_last[d]),
      .wrap_o    (w_wrap[d])
    );

    assign w_adv[d+1] = w_wrap[d];
  end

  assign w_unused = ^{test_mode_i, ctrl_i, r_stride[0],
                      w_first, w_last};

  // job FSM with registered beat, flags and control snapshot
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state     <= AG_IDLE;
      r_base      <= '0;
      r_len       <= '0;
      r_stride    <= '0;
      r_valid     <= 1'b0;
      r_addr      <= '0;
      r_strb      <= '0;
      r_first     <= 1'b0;
      r_last_line <= 1'b0;
      r_dim_wrap  <= '0;
      r_last_beat <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_beat_cnt  <= '0;
    end else if (clear_i) begin
      r_state     <= AG_IDLE;
      r_base      <= '0;
      r_len       <= '0;
      r_stride    <= '0;
      r_valid     <= 1'b0;
      r_addr      <= '0;
      r_strb      <= '0;
      r_first     <= 1'b0;
      r_last_line <= 1'b0;
      r_dim_wrap  <= '0;
      r_last_beat <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_beat_cnt  <= '0;
    end else begin
      r_done <= 1'b0;
      if (w_launch) begin
        r_valid     <= 1'b1;
        r_addr      <= w_addr;
        r_strb      <= w_strb;
        r_first     <= w_first[0];
        r_last_line <= w_last[0];
        r_dim_wrap  <= w_wrap;
        r_last_beat <= w_adv[NB_DIMS];
      end else if (w_hs) begin
        r_valid <= 1'b0;
      end
      if (w_hs && (r_beat_cnt != '1)) begin
        r_beat_cnt <= r_beat_cnt + TOT_CNT'(1);
      end
      unique case (r_state)
        AG_IDLE: begin
          if (w_accept) begin
            r_state    <= AG_RUN;
            r_busy     <= 1'b1;
            r_beat_cnt <= '0;
            r_base     <= ctrl_i.base_addr;
            for (int d = 0; d < NB_DIMS; d++) begin
              r_len[d]    <= ctrl_i.length[d][CNT-1:0];
              r_stride[d] <= ctrl_i.stride[d];
            end
          end
        end
        AG_RUN: begin
          if (w_hs && r_last_beat) begin
            r_state     <= AG_DONE;
            r_busy      <= 1'b0;
            r_done      <= 1'b1;
            r_last_beat <= 1'b0;
          end
        end
        AG_DONE: r_state <= AG_IDLE;
        default: r_state <= AG_IDLE;
      endcase
    end
  end

  assign addr_valid_o = r_valid;
  assign addr_o       = r_addr;
  assign strb_o       = r_strb;

  // pack registered flags into the max-sized bundle
  always_comb begin
    flags_o                            = '0;
    flags_o.busy                       = r_busy;
    flags_o.done                       = r_done;
    flags_o.first_of_line              = r_first;
    flags_o.last_of_line               = r_last_line;
    flags_o.dim_wrap[NB_DIMS-1:0]      = r_dim_wrap;
    flags_o.beat_cnt[TOT_CNT-1:0]      = r_beat_cnt;
  end

endmodule

// File: tb/tb_hwpe_stream_addressgen_nd.sv
// Bench for the N-D address generator: nested-loop beat model,
// per-cycle compare, handshake hold checks and directed jobs.
module tb_hwpe_stream_addressgen_nd;
  import hwpe_stream_package::*;

  logic clk_i = 1'b0;
  logic rst_ni = 1'b0;
  logic test_mode_i = 1'b0;
  logic enable_i = 1'b1;
  logic clear_i = 1'b0;
  logic start_i = 1'b0;
  logic addr_ready_i = 1'b0;
  ctrl_addressgen_nd_t  ctrl_i = '0;
  logic                 addr_valid_o;
  logic [31:0]          addr_o;
  logic [3:0]           strb_o;
  flags_addressgen_nd_t flags_o;

  hwpe_stream_addressgen_nd #(
    .NB_DIMS (3),
    .STEP    (4),
    .CNT     (16),
    .TOT_CNT (32)
  ) dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .test_mode_i  (test_mode_i),
    .enable_i     (enable_i),
    .clear_i      (clear_i),
    .start_i      (start_i),
    .ctrl_i       (ctrl_i),
    .addr_valid_o (addr_valid_o),
    .addr_ready_i (addr_ready_i),
    .addr_o       (addr_o),
    .strb_o       (strb_o),
    .flags_o      (flags_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  strb;
    logic        first;
    logic        last;
    logic [2:0]  wrap;
  } beat_t;

  beat_t exp_q[$];
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int beats_seen = 0;
  int done_cnt = 0;
  int done_cyc = 0;
  int rdy_mode = 0;
  int rdy_idx = 0;
  logic [3:0] rdy_pat = 4'b1001;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  // Reference: walk the loop nest with plain arithmetic
  task automatic build_exp(input logic [31:0] base, input int l0,
                           input int l1, input int l2,
                           input logic [31:0] s1,
                           input logic [31:0] s2);
    int e0, e1, e2, off, nb;
    logic [31:0] s;
    logic [3:0] hd;
    beat_t b;
    e0 = (l0 == 0) ? 1 : l0;
    e1 = (l1 == 0) ? 1 : l1;
    e2 = (l2 == 0) ? 1 : l2;
    for (int j2 = 0; j2 < e2; j2++) begin
      for (int j1 = 0; j1 < e1; j1++) begin
        s = base + s1 * 32'(j1) + s2 * 32'(j2);
        off = int'(s[1:0]);
        nb = e0 + ((off != 0) ? 1 : 0);
        hd = 4'hF << off;
        for (int k = 0; k < nb; k++) begin
          b.addr = {s[31:2], 2'b00} + 32'(4 * k);
          b.strb = 4'hF;
          if (k == 0) b.strb = b.strb & hd;
          if (k == nb - 1 && off != 0) b.strb = b.strb & ~hd;
          b.first = (k == 0);
          b.last = (k == nb - 1);
          b.wrap[0] = b.last;
          b.wrap[1] = b.last && (j1 == e1 - 1);
          b.wrap[2] = b.wrap[1] && (j2 == e2 - 1);
          exp_q.push_back(b);
        end
      end
    end
  endtask

  initial begin
    forever begin
      @(posedge clk_i);
      cyc++;
      #1;
      if (rdy_mode == 1) begin
        addr_ready_i = rdy_pat[rdy_idx % 4];
        rdy_idx++;
      end else if (rdy_mode == 0) begin
        addr_ready_i = 1'b1;
      end else begin
        addr_ready_i = 1'b0;
      end
    end
  end

  // Per-cycle compare against the model queue
  initial begin
    beat_t e;
    logic pstall;
    logic [31:0] paddr;
    logic [3:0] pstrb;
    logic [1:0] pfl;
    pstall = 1'b0;
    paddr = '0;
    pstrb = '0;
    pfl = '0;
    forever begin
      @(negedge clk_i);
      if (!rst_ni || clear_i) begin
        pstall = 1'b0;
      end else begin
        if (flags_o.done) begin
          done_cnt++;
          done_cyc = cyc;
        end
        if (pstall) begin
          chk("hold_valid", 64'(addr_valid_o), 64'd1);
          chk("hold_addr", 64'(addr_o), 64'(paddr));
          chk("hold_strb", 64'(strb_o), 64'(pstrb));
          chk("hold_flags",
              64'({flags_o.first_of_line, flags_o.last_of_line}),
              64'(pfl));
        end
        pstall = 1'b0;
        if (addr_valid_o) begin
          if (addr_ready_i) begin
            if (exp_q.size() == 0) begin
              checks++;
              errors++;
              $display("FAIL extra_beat actual=%0h required=none",
                       addr_o);
            end else begin
              e = exp_q.pop_front();
              chk("addr", 64'(addr_o), 64'(e.addr));
              chk("strb", 64'(strb_o), 64'(e.strb));
              chk("first", 64'(flags_o.first_of_line), 64'(e.first));
              chk("last", 64'(flags_o.last_of_line), 64'(e.last));
              chk("dim_wrap", 64'(flags_o.dim_wrap),
                  64'({1'b0, e.wrap}));
            end
            beats_seen++;
          end else begin
            pstall = 1'b1;
            paddr = addr_o;
            pstrb = strb_o;
            pfl = {flags_o.first_of_line, flags_o.last_of_line};
          end
        end
      end
    end
  end

  task automatic set_ctrl(input logic [31:0] base, input int l0,
                          input int l1, input int l2,
                          input logic [31:0] s1,
                          input logic [31:0] s2);
    ctrl_i = '0;
    ctrl_i.base_addr = base;
    ctrl_i.length[0] = 32'(l0);
    ctrl_i.length[1] = 32'(l1);
    ctrl_i.length[2] = 32'(l2);
    ctrl_i.stride[1] = s1;
    ctrl_i.stride[2] = s2;
  endtask

  task automatic start_job(output int st);
    @(posedge clk_i);
    #1;
    start_i = 1'b1;
    st = cyc;
    @(posedge clk_i);
    #1;
    start_i = 1'b0;
    ctrl_i.base_addr = $urandom;
    ctrl_i.length[0] = 32'($urandom_range(1, 9));
    ctrl_i.stride[1] = $urandom;
    chk("busy_after_start", 64'(flags_o.busy), 64'd1);
  endtask

  task automatic wait_done(input int d0, input string nm);
    int n;
    n = 0;
    while (done_cnt == d0 && n < 600) begin
      @(posedge clk_i);
      #2;
      n++;
    end
    if (done_cnt == d0) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout actual=no_done required=done", nm);
    end
    @(posedge clk_i);
    #2;
    chk({nm, "_drain"}, 64'(exp_q.size()), 64'd0);
    chk({nm, "_busy"}, 64'(flags_o.busy), 64'd0);
  endtask

  task automatic wait_beats(input int target);
    int n;
    n = 0;
    while (beats_seen < target && n < 200) begin
      @(posedge clk_i);
      #1;
      n++;
    end
    if (beats_seen < target) begin
      checks++;
      errors++;
      $display("FAIL wait_beats actual=%0d required=%0d",
               beats_seen, target);
    end
  endtask

  initial begin
    int st, d0, b0;
    repeat (3) @(posedge clk_i);
    #1;
    chk("rst_valid", 64'(addr_valid_o), 64'd0);
    chk("rst_addr", 64'(addr_o), 64'd0);
    chk("rst_strb", 64'(strb_o), 64'd0);
    chk("rst_flags", 64'(flags_o), 64'd0);
    rst_ni = 1'b1;

    // aligned 2D, full throughput
    rdy_mode = 0;
    set_ctrl(32'h100, 4, 3, 0, 32'h40, 32'h0);
    build_exp(32'h100, 4, 3, 0, 32'h40, 32'h0);
    chk("model_a4", 64'(exp_q[4].addr), 64'h140);
    chk("model_a11", 64'(exp_q[11].addr), 64'h18C);
    chk("model_aw3", 64'(exp_q[3].wrap), 64'h1);
    chk("model_aw11", 64'(exp_q[11].wrap), 64'h7);
    d0 = done_cnt;
    b0 = beats_seen;
    start_job(st);
    wait_done(d0, "aligned");
    chk("aligned_lat", 64'(done_cyc - st), 64'd13);
    chk("aligned_beats", 64'(beats_seen - b0), 64'd12);
    chk("aligned_bcnt", 64'(flags_o.beat_cnt), 64'd12);

    // misaligned single line
    set_ctrl(32'h102, 2, 1, 0, 32'h0, 32'h0);
    build_exp(32'h102, 2, 1, 0, 32'h0, 32'h0);
    chk("model_m0", 64'({exp_q[0].addr, exp_q[0].strb}), 64'h100C);
    chk("model_m1", 64'({exp_q[1].addr, exp_q[1].strb}), 64'h104F);
    chk("model_m2", 64'({exp_q[2].addr, exp_q[2].strb}), 64'h1083);
    chk("model_mfl", 64'({exp_q[0].first, exp_q[2].last}), 64'h3);
    d0 = done_cnt;
    start_job(st);
    wait_done(d0, "misal");
    chk("misal_bcnt", 64'(flags_o.beat_cnt), 64'd3);

    // negative stride wrap
    set_ctrl(32'h0, 1, 2, 0, 32'hFFFF_FFFC, 32'h0);
    build_exp(32'h0, 1, 2, 0, 32'hFFFF_FFFC, 32'h0);
    chk("model_n1", 64'(exp_q[1].addr), 64'hFFFF_FFFC);
    chk("model_nw0", 64'(exp_q[0].wrap), 64'h1);
    chk("model_nw1", 64'(exp_q[1].wrap), 64'h7);
    d0 = done_cnt;
    start_job(st);
    wait_done(d0, "negstr");

    // backpressure pattern 1,0,0,1
    rdy_mode = 1;
    set_ctrl(32'h100, 4, 3, 0, 32'h40, 32'h0);
    build_exp(32'h100, 4, 3, 0, 32'h40, 32'h0);
    d0 = done_cnt;
    b0 = beats_seen;
    start_job(st);
    wait_done(d0, "bp");
    chk("bp_beats", 64'(beats_seen - b0), 64'd12);
    chk("bp_bcnt", 64'(flags_o.beat_cnt), 64'd12);

    // 3D, one-word misaligned lines
    set_ctrl(32'h203, 1, 2, 2, 32'h10, 32'hFFFF_FF00);
    build_exp(32'h203, 1, 2, 2, 32'h10, 32'hFFFF_FF00);
    chk("model_3s", 64'({exp_q[0].strb, exp_q[1].strb}), 64'h87);
    chk("model_3a", 64'(exp_q[4].addr), 64'h100);
    d0 = done_cnt;
    start_job(st);
    wait_done(d0, "3d");
    chk("3d_bcnt", 64'(flags_o.beat_cnt), 64'd8);

    // enable stall mid-job
    rdy_mode = 0;
    set_ctrl(32'h100, 4, 3, 0, 32'h40, 32'h0);
    build_exp(32'h100, 4, 3, 0, 32'h40, 32'h0);
    d0 = done_cnt;
    b0 = beats_seen;
    start_job(st);
    wait_beats(b0 + 3);
    enable_i = 1'b0;
    b0 = beats_seen;
    repeat (5) @(posedge clk_i);
    #1;
    chk("en_stall_beats", 64'(beats_seen - b0 <= 1), 64'd1);
    chk("en_stall_valid", 64'(addr_valid_o), 64'd0);
    enable_i = 1'b1;
    wait_done(d0, "enstall");
    chk("en_bcnt", 64'(flags_o.beat_cnt), 64'd12);

    // clear with a stalled valid beat
    rdy_mode = 2;
    set_ctrl(32'h100, 4, 3, 0, 32'h40, 32'h0);
    d0 = done_cnt;
    start_job(st);
    @(posedge clk_i);
    #1;
    chk("clr_pre_valid", 64'(addr_valid_o), 64'd1);
    clear_i = 1'b1;
    @(posedge clk_i);
    #1;
    clear_i = 1'b0;
    exp_q.delete();
    chk("clr_valid", 64'(addr_valid_o), 64'd0);
    chk("clr_busy", 64'(flags_o.busy), 64'd0);
    chk("clr_bcnt", 64'(flags_o.beat_cnt), 64'd0);
    repeat (5) @(posedge clk_i);
    #2;
    chk("clr_no_done", 64'(done_cnt - d0), 64'd0);

    // fresh job after clear
    rdy_mode = 1;
    set_ctrl(32'h203, 1, 2, 2, 32'h10, 32'hFFFF_FF00);
    build_exp(32'h203, 1, 2, 2, 32'h10, 32'hFFFF_FF00);
    d0 = done_cnt;
    b0 = beats_seen;
    start_job(st);
    wait_done(d0, "post_clr");
    chk("post_clr_beats", 64'(beats_seen - b0), 64'd8);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/hwpe_stream_addressgen_nd.md
Name: hwpe_stream_addressgen_nd

Overview:
- N-dimensional streaming address generator, successor of the 3-loop (word/line/feat) generator.
- Sits in front of TCDM source/sink streamers. Emits one word-aligned address plus byte strobe per beat on a valid/ready handshake.
- Loop depth, counter width and word size are parameters. Misalignment is resolved per innermost line, not globally.
- Control is latched at start, so software may reprogram ctrl_i while a job runs.

Parameters:
- NB_DIMS, 3, number of nested loops (dim 0 = innermost, contiguous words); legal range 1..4.
- STEP, 4, bytes per word; power of two, 2..32.
- CNT, 16, bit width of each per-dimension length and counter.
- TOT_CNT, 32, bit width of the beat counter.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- test_mode_i  in  1  test mode, no functional effect
- enable_i  in  1  local enable; when low, the FSM does not advance and no new beat is launched
- clear_i  in  1  synchronous clear to reset state
- start_i  in  1  single-cycle job start pulse
- ctrl_i  in  ctrl_addressgen_nd_t  base_addr[31:0], length[NB_DIMS][CNT], stride[NB_DIMS-1:1] signed [31:0]
- addr_valid_o  out  1  beat valid
- addr_ready_i  in  1  consumer ready
- addr_o  out  32  word-aligned address, low log2(STEP) bits zero
- strb_o  out  STEP  byte strobe
- flags_o  out  flags_addressgen_nd_t  busy, done (1-cycle pulse), first_of_line, last_of_line, dim_wrap[NB_DIMS-1:0], beat_cnt[TOT_CNT-1:0]

Behaviour:
- Reset and clear values:
  - FSM in IDLE, all counters and accumulators 0.
  - addr_valid_o=0, addr_o=0, strb_o=0.
  - All flags 0.
- FSM states:
  - IDLE: waits for start_i & enable_i. On that cycle ctrl_i is latched and the state moves to RUN. start_i in RUN or DONE is ignored.
  - RUN: generates beats (rules below). When the last beat's handshake completes, moves to DONE.
  - DONE: lasts one cycle, pulses flags_o.done, then returns to IDLE.
- Output timing and handshake:
  - Output is registered. The first beat is valid the cycle after start is accepted.
  - A beat completes on addr_valid_o & addr_ready_i.
  - While addr_valid_o=1 and addr_ready_i=0: addr_o, strb_o and the line flags hold stable.
  - Next beat is loaded on the completing edge if enable_i=1; otherwise valid drops after the handshake.
  - Full throughput: one beat per cycle under constant ready and enable.
  - enable_i=0 never retracts a valid beat already presented.
- Address arithmetic:
  - Line start address S = base + sum over d>=1 of cnt_d*stride_d, built incrementally with adders only, no multipliers.
  - All arithmetic is mod 2^32. Strides are sign-extended to 32 bits.
  - Offset off = S[log2(STEP)-1:0].
- Per-line beat sequence:
  - off==0: length[0] beats at S, S+STEP, …; strb='1.
  - off!=0: length[0]+1 beats starting at S&~(STEP-1).
  - First beat strb = '1<<off. Last beat strb = ~('1<<off). Middle beats strb = '1.
  - If length[0]=1 and off!=0: two beats with exactly those first and last strobes.
- Counters and loop advance:
  - Any length of 0 is treated as 1.
  - On the last beat of dim d, counter d wraps to 0 and counter d+1 increments. flags_o.dim_wrap[d]=1 on that beat (registered with the beat).
  - The job ends when every dimension wraps simultaneously.
- Line flags: first_of_line and last_of_line are asserted with the corresponding beat. Both are 1 for a one-beat aligned line.
- busy=1 from start acceptance through the last handshake.
- beat_cnt counts completed handshakes, saturates at all-ones, and clears on start.
- clear_i takes priority over everything, including mid-job with valid pending. Valid drops the next cycle and no done pulse is emitted.
- Asynchronous reset mid-job has the same effect, immediately.

Decomposition:
- Package hwpe_stream_package gains:
  - ctrl_addressgen_nd_t, flags_addressgen_nd_t
  - constant HWPE_STREAM_ADDRESSGEN_ND_MAX_DIMS = 4
- One natural sub-module, hwpe_stream_addressgen_nd_cnt:
  - one loop dimension holding counter, length compare, and stride accumulator
  - inputs: advance; outputs: wrap
  - instantiated NB_DIMS times in a generate chain

Test Plan:
- Aligned 2D: base=0x100, len={4,3}, stride1=0x40, ready=1 → 12 beats 0x100..0x10C, 0x140.., 0x180..; all strb=4'hF; done 13 cycles after start.
- Misaligned line: base=0x102, len={2,1} → beats 0x100 strb 4'hC, 0x104 strb 4'hF, 0x108 strb 4'h3; first/last flags on beats 1/3.
- Negative stride and wrap: base=0x0, len={1,2}, stride1=-4 → addresses 0x0, 0xFFFFFFFC; dim_wrap[1] on beat 2.
- Backpressure: ready toggles 1,0,0,1 on the aligned 2D job → addr/strb stable while stalled; 12 handshakes total; beat_cnt=12.
- enable_i low for 5 cycles mid-job → no new beats; pending beat held; job resumes; sequence identical to the unstalled run.
- clear_i mid-job with valid high and ready low → valid=0 next cycle, busy=0, no done pulse; a new start then runs correctly.
